mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//   Sits between the EX/MEM pipeline register and the word-addressed data memory.
//   Converts byte/halfword/word load/store requests into 32-bit aligned memory accesses.
//   Loads: lane extraction plus sign/zero extension.
//   Sub-word stores: 2-cycle read-modify-write; the pipeline is stalled during the first cycle.
// PARAMETERS
//   ADDR_WIDTH     32  width of req_addr / mem_addr
//   RMW_CNT_WIDTH  16  width of the saturating RMW event counter
// PORTS
//   clk          in   1           clock, rising edge
//   reset        in   1           asynchronous, active-high
//   req_valid    in   1           request present from EX/MEM
//   req_read     in   1           load request
//   req_write    in   1           store request
//   req_size     in   2           00 byte, 01 half, 10 word, 11 reserved (treated as word)
//   req_signed   in   1           load sign-extends when 1, zero-extends when 0
//   req_addr     in   ADDR_WIDTH  byte address
//   req_wdata    in   32          store data, right-justified
//   stall        out  1           hold EX/MEM and earlier stages this cycle
//   rsp_valid    out  1           rsp_rdata valid this cycle
//   rsp_rdata    out  32          extended load result to MEM/WB
//   mem_addr     out  ADDR_WIDTH  memory address, bits[1:0] always 00
//   mem_wdata    out  32          memory write data
//   mem_read     out  1           memory read enable
//   mem_write    out  1           memory write enable, sampled on the memory's clk edge
//   mem_rdata    in   32          memory read data, combinational from mem_addr
//   rmw_count    out  RMW_CNT_WIDTH  number of completed RMW stores, saturating
// BEHAVIOUR
//   Reset
//     - state=IDLE, held word and address cleared, rmw_count=0.
//     - While reset is high, every output is 0.
//   Lane selection
//     - lane=req_addr[1:0]; word-aligned address = {req_addr[ADDR_WIDTH-1:2],2'b00}.
//     - Byte lane k occupies bits [8k+7:8k]. Half uses lane[1] only (bits [15:0] or [31:16]).
//   Command decode
//     - Active only when req_valid=1.
//     - Write has priority: req_read and req_write both 1 -> treated as a store, rsp_valid=0.
//   States: IDLE, RMW_WR.
//   IDLE, load
//     - mem_read=1, mem_addr=aligned address.
//     - rsp_valid=1 in the same cycle; rsp_rdata = extracted lane, extended per req_signed.
//     - stall=0. Latency 0 (combinational, same cycle).
//   IDLE, word store
//     - mem_write=1, mem_wdata=req_wdata, stall=0; completes at the next edge.
//   IDLE, byte/half store
//     - mem_read=1, stall=1.
//     - At the edge: held_word <= mem_rdata with the target lane(s) replaced by req_wdata[7:0] or [15:0].
//     - At the edge: held_addr <= aligned address; then -> RMW_WR.
//   RMW_WR
//     - mem_write=1, mem_addr=held_addr, mem_wdata=held_word, stall=0, mem_read=0.
//     - Upstream still presents the same request because of the previous stall; it is ignored.
//     - At the edge: -> IDLE; rmw_count += 1, saturating at all-ones.
//   Cycle counts: sub-word store occupies exactly 2 cycles; every other request occupies 1.
//   No valid request: all mem_* and rsp_* outputs 0, stall=0.
//   Reset asserted in RMW_WR: the write is abandoned (mem_write forced 0) and state returns to IDLE.
//   rsp_rdata is 0 whenever rsp_valid=0.
// CONFIGURATION
//   MEM_ACCESS_MISALIGN_TRAP_EN
//     Defined:
//       - Adds output misalign_exc (1 bit, reset 0).
//       - Misaligned = half with addr[0]=1, or word with addr[1:0]!=0.
//       - On a misaligned valid request: misalign_exc=1 that cycle, no memory access, stall=0, rsp_valid=0.
//     Undefined:
//       - No port.
//       - Misaligned address bits below the access size are ignored (half uses addr[1], word uses addr[1:0]=00).
// TESTING
//   1. Pre-load word 0x0 = 0x8899AABB, 0x4 = 0x11223344 for the loads below.
//      - lb signed addr 0x1 -> rsp_rdata=0xFFFFFFAA, rsp_valid=1, stall=0.
//      - lbu addr 0x1 -> 0x000000AA.
//      - lh signed addr 0x2 -> 0xFFFF8899.
//      - lhu addr 0x2 -> 0x00008899.
//   2. Word store 0xDEADBEEF to addr 0x8: mem_write=1 for one cycle, stall=0; lw 0x8 -> 0xDEADBEEF.
//   3. sb 0x5A to addr 0x6 (word 0x4 holds 0x11223344):
//      - cycle 1: stall=1, mem_read=1.
//      - cycle 2: mem_write=1, mem_wdata=0x115A3344, stall=0.
//      - rmw_count=1.
//   4. sh 0xCAFE to addr 0x0 (holds 0x8899AABB): mem_wdata=0x8899CAFE.
//      - Back-to-back sh to 0x2: second RMW starts the cycle after RMW_WR and reads the updated word.
//   5. Assert reset during RMW_WR of sb to 0x4:
//      - word 0x4 is unchanged.
//      - outputs are 0, state is IDLE, rmw_count=0.
//   6. With MEM_ACCESS_MISALIGN_TRAP_EN: lw addr 0x2 -> misalign_exc=1, mem_read=0, rsp_valid=0.
//      - Without the macro: lw addr 0x2 reads word 0x0.

Source files
------------

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//   Bridges the EX/MEM pipeline register to a word-addressed data memory.
//   Loads are served combinationally: the lane is extracted from the aligned
//   word and sign/zero extended. Word stores are written directly. Byte and
//   halfword stores use a two-cycle read-modify-write: cycle 1 reads the word
//   and stalls the pipeline; cycle 2 writes back the merged word.
//
// Parameters
//   ADDR_WIDTH     width of req_addr / mem_addr
//   RMW_CNT_WIDTH  width of the saturating completed-RMW counter
//
// Ports
//   clk, reset                clock (rising edge), asynchronous active-high reset
//   req_valid/read/write      request qualifiers; write wins over read
//   req_size                  00 byte, 01 half, 10/11 word
//   req_signed                sign-extend loads when 1
//   req_addr, req_wdata       byte address, right-justified store data
//   stall                     hold EX/MEM and earlier stages this cycle
//   rsp_valid, rsp_rdata      extended load result (0 when not valid)
//   mem_addr/wdata/read/write memory interface, mem_addr always word aligned
//   mem_rdata                 combinational read data from mem_addr
//   rmw_count                 completed RMW stores, saturating
//   misalign_exc              (MEM_ACCESS_MISALIGN_TRAP_EN only) misaligned
//                             half/word request flag
//
// Configuration macro: MEM_ACCESS_MISALIGN_TRAP_EN
//   Undefined: address bits below the access size are ignored.
//   Defined:   misaligned half/word requests raise misalign_exc and perform
//              no memory access.
// -----------------------------------------------------------------------------
module mem_access_unit #(
  parameter int ADDR_WIDTH    = 32,
  parameter int RMW_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  input  logic                     req_read,
  input  logic                     req_write,
  input  logic [1:0]               req_size,
  input  logic                     req_signed,
  input  logic [ADDR_WIDTH-1:0]    req_addr,
  input  logic [31:0]              req_wdata,
  output logic                     stall,
  output logic                     rsp_valid,
  output logic [31:0]              rsp_rdata,
  output logic [ADDR_WIDTH-1:0]    mem_addr,
  output logic [31:0]              mem_wdata,
  output logic                     mem_read,
  output logic                     mem_write,
  input  logic [31:0]              mem_rdata,
  output logic [RMW_CNT_WIDTH-1:0] rmw_count
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  ,
  output logic                     misalign_exc
`endif
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_RMW_WR = 1'b1;

  localparam logic [RMW_CNT_WIDTH-1:0] CNT_ONE = RMW_CNT_WIDTH'(1);
  localparam logic [RMW_CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [0:0]               r_state;
  logic [31:0]              r_held_word;
  logic [ADDR_WIDTH-1:0]    r_held_addr;
  logic [RMW_CNT_WIDTH-1:0] r_rmw_count;

  logic [1:0]               w_lane;
  logic [ADDR_WIDTH-1:0]    w_aligned;
  logic                     w_is_store;
  logic                     w_is_load;
  logic                     w_is_word;
  logic                     w_misalign;
  logic                     w_start_rmw;
  logic [31:0]              w_load_data;
  logic [31:0]              w_merged;

  // Extract the addressed lane(s) from a word and extend to 32 bits.
  function automatic logic [31:0] extract_load(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic        sgn,
                                               input logic [1:0]  lane);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   res = {{24{sgn & b[7]}}, b};
      2'b01:   res = {{16{sgn & h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  // Replace the target lane(s) of a word with right-justified store data.
  function automatic logic [31:0] merge_store(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane,
                                              input logic [31:0] wdata);
    logic [31:0] res;
    res = word;
    if (size == 2'b00) begin
      res[{lane, 3'b000} +: 8] = wdata[7:0];
    end else begin
      res[{lane[1], 4'b0000} +: 16] = wdata[15:0];
    end
    return res;
  endfunction

  assign w_lane     = req_addr[1:0];
  assign w_aligned  = {req_addr[ADDR_WIDTH-1:2], 2'b00};
  assign w_is_store = req_valid & req_write;
  assign w_is_load  = req_valid & req_read & ~req_write;
  // Reserved size 11 behaves as a word access.
  assign w_is_word  = req_size[1];

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  assign w_misalign = req_valid & (req_read | req_write) &
                      (((req_size == 2'b01) & req_addr[0]) |
                       (req_size[1] & (|req_addr[1:0])));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_start_rmw = (r_state == S_IDLE) & w_is_store & ~w_is_word & ~w_misalign;
  assign w_load_data = extract_load(mem_rdata, req_size, req_signed, w_lane);
  assign w_merged    = merge_store(mem_rdata, req_size, w_lane, req_wdata);

  // Output decode; everything is forced low while reset is asserted, which
  // also abandons a write that is in flight in RMW_WR.
  always_comb begin
    stall     = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = 32'h0;
    mem_addr  = '0;
    mem_wdata = 32'h0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    misalign_exc = 1'b0;
`endif
    if (!reset) begin
      if (r_state == S_RMW_WR) begin
        // The upstream request is still presented here but is ignored.
        mem_write = 1'b1;
        mem_addr  = r_held_addr;
        mem_wdata = r_held_word;
      end else if (w_misalign) begin
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        misalign_exc = 1'b1;
`endif
      end else if (w_is_store) begin
        mem_addr = w_aligned;
        if (w_is_word) begin
          mem_write = 1'b1;
          mem_wdata = req_wdata;
        end else begin
          mem_read = 1'b1;
          stall    = 1'b1;
        end
      end else if (w_is_load) begin
        mem_addr  = w_aligned;
        mem_read  = 1'b1;
        rsp_valid = 1'b1;
        rsp_rdata = w_load_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_held_word <= 32'h0;
      r_held_addr <= '0;
      r_rmw_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start_rmw) begin
            r_held_word <= w_merged;
            r_held_addr <= w_aligned;
            r_state     <= S_RMW_WR;
          end
        end
        default: begin
          r_state <= S_IDLE;
          if (r_rmw_count != CNT_MAX) begin
            r_rmw_count <= r_rmw_count + CNT_ONE;
          end
        end
      endcase
    end
  end

  assign rmw_count = reset ? '0 : r_rmw_count;

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
//   Drives mem_access_unit against a small word memory and compares every
//   request with a byte-level reference model of memory contents, load
//   results and the completed-RMW counter. The counter is narrowed so its
//   saturation point is reached within the random sequence.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

  localparam int AW = 32;
  localparam int CW = 4;
  localparam int CNT_SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_read, req_write, req_signed;
  logic [1:0]    req_size;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          stall, rsp_valid, mem_read, mem_write;
  logic [31:0]   rsp_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic [CW-1:0] rmw_count;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  logic          misalign_exc;
`endif

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_WIDTH(AW), .RMW_CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_read(req_read), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .stall(stall), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata),
    .rmw_count(rmw_count)
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    , .misalign_exc(misalign_exc)
`endif
  );

  // Memory seen by the DUT: combinational read, write on the clock edge.
  logic [31:0] mem [0:15];
  logic        pre_we;
  logic [3:0]  pre_idx;
  logic [31:0] pre_data;
  assign mem_rdata = mem[mem_addr[5:2]];
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[5:2]] <= mem_wdata;
    else if (pre_we) mem[pre_idx] <= pre_data;
  end

  // Reference model state.
  logic [31:0] ref_mem [0:15];
  int exp_cnt;
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_load(input logic [31:0] w, input logic [1:0] sz,
                                           input logic sg, input logic [1:0] ln);
    logic [31:0] v;
    if (sz[1]) return w;
    if (sz == 2'b00) begin
      v = (w >> (8 * ln)) & 32'hFF;
      if (sg && v[7]) v = v | 32'hFFFFFF00;
    end else begin
      v = (w >> (16 * ln[1])) & 32'hFFFF;
      if (sg && v[15]) v = v | 32'hFFFF0000;
    end
    return v;
  endfunction

  function automatic logic [31:0] exp_merge(input logic [31:0] w, input logic [1:0] sz,
                                            input logic [1:0] ln, input logic [31:0] d);
    logic [31:0] m;
    if (sz == 2'b00) begin
      m = 32'hFF << (8 * ln);
      return (w & ~m) | ((d & 32'hFF) << (8 * ln));
    end
    m = 32'hFFFF << (16 * ln[1]);
    return (w & ~m) | ((d & 32'hFFFF) << (16 * ln[1]));
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, "_stall"}, 32'(stall), 32'h0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
    check({tag, "_mem_addr"}, mem_addr, 32'h0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    check({tag, "_mem_read"}, 32'(mem_read), 32'h0);
    check({tag, "_mem_write"}, 32'(mem_write), 32'h0);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    check({tag, "_exc"}, 32'(misalign_exc), 32'h0);
`endif
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    req_valid = 1'b0;
    req_read = 1'($urandom); req_write = 1'($urandom); req_size = 2'($urandom);
    req_signed = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    #1;
    check_quiet("noreq");
  endtask

  // Present one request; returns with it still driven in its last cycle.
  task automatic do_req(input logic rd, input logic wr, input logic [1:0] sz,
                        input logic sg, input logic [31:0] addr, input logic [31:0] wd);
    int idx;
    logic [31:0] al, nw;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    logic mis;
    mis = (rd || wr) && ((sz == 2'b01 && addr[0]) || (sz[1] && addr[1:0] != 2'b00));
`endif
    idx = int'(addr[5:2]);
    al  = {addr[31:2], 2'b00};
    @(negedge clk);
    req_valid = 1'b1; req_read = rd; req_write = wr; req_size = sz;
    req_signed = sg; req_addr = addr; req_wdata = wd;
    #1;
    check("rmw_count", 32'(rmw_count), 32'(exp_cnt));
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    check("misalign_exc", 32'(misalign_exc), 32'(mis));
    if (mis) begin
      check("mis_mem_read", 32'(mem_read), 32'h0);
      check("mis_mem_write", 32'(mem_write), 32'h0);
      check("mis_rsp_valid", 32'(rsp_valid), 32'h0);
      check("mis_stall", 32'(stall), 32'h0);
      return;
    end
`endif
    if (wr) begin
      check("st_rsp_valid", 32'(rsp_valid), 32'h0);
      check("st_rsp_rdata", rsp_rdata, 32'h0);
      check("st_mem_addr", mem_addr, al);
      if (sz[1]) begin
        check("sw_mem_write", 32'(mem_write), 32'h1);
        check("sw_mem_read", 32'(mem_read), 32'h0);
        check("sw_mem_wdata", mem_wdata, wd);
        check("sw_stall", 32'(stall), 32'h0);
        ref_mem[idx] = wd;
      end else begin
        check("rmw1_stall", 32'(stall), 32'h1);
        check("rmw1_mem_read", 32'(mem_read), 32'h1);
        check("rmw1_mem_write", 32'(mem_write), 32'h0);
        nw = exp_merge(ref_mem[idx], sz, addr[1:0], wd);
        @(negedge clk);
        #1;
        check("rmw2_stall", 32'(stall), 32'h0);
        check("rmw2_mem_write", 32'(mem_write), 32'h1);
        check("rmw2_mem_read", 32'(mem_read), 32'h0);
        check("rmw2_mem_addr", mem_addr, al);
        check("rmw2_mem_wdata", mem_wdata, nw);
        check("rmw2_rsp_valid", 32'(rsp_valid), 32'h0);
        ref_mem[idx] = nw;
        exp_cnt = (exp_cnt < CNT_SAT) ? exp_cnt + 1 : CNT_SAT;
      end
    end else if (rd) begin
      check("ld_rsp_valid", 32'(rsp_valid), 32'h1);
      check("ld_rsp_rdata", rsp_rdata, exp_load(ref_mem[idx], sz, sg, addr[1:0]));
      check("ld_stall", 32'(stall), 32'h0);
      check("ld_mem_read", 32'(mem_read), 32'h1);
      check("ld_mem_write", 32'(mem_write), 32'h0);
      check("ld_mem_addr", mem_addr, al);
    end else begin
      check("nocmd_stall", 32'(stall), 32'h0);
      check("nocmd_mem_read", 32'(mem_read), 32'h0);
      check("nocmd_mem_write", 32'(mem_write), 32'h0);
      check("nocmd_rsp_valid", 32'(rsp_valid), 32'h0);
    end
  endtask

  initial begin
    reset = 1'b1;
    pre_we = 1'b0; pre_idx = '0; pre_data = '0;
    req_valid = 1'b1; req_read = 1'b1; req_write = 1'b0; req_size = 2'b10;
    req_signed = 1'b0; req_addr = 32'h4; req_wdata = 32'h0;
    exp_cnt = 0;
    #2;
    check_quiet("reset");
    check("reset_rmw_count", 32'(rmw_count), 32'h0);

    // Preload memory while reset holds the DUT quiet.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      pre_we   = 1'b1;
      pre_idx  = 4'(i);
      pre_data = (i == 0) ? 32'h8899AABB : (i == 1) ? 32'h11223344 : $urandom;
      ref_mem[i] = pre_data;
    end
    @(negedge clk);
    pre_we = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_quiet("post_reset");

    // Loads with extension.
    do_req(1, 0, 2'b00, 1, 32'h1, 0);  check("lb", rsp_rdata, 32'hFFFFFFAA);
    do_req(1, 0, 2'b00, 0, 32'h1, 0);  check("lbu", rsp_rdata, 32'h000000AA);
    do_req(1, 0, 2'b01, 1, 32'h2, 0);  check("lh", rsp_rdata, 32'hFFFF8899);
    do_req(1, 0, 2'b01, 0, 32'h2, 0);  check("lhu", rsp_rdata, 32'h00008899);

    // Word store then read back.
    do_req(0, 1, 2'b10, 0, 32'h8, 32'hDEADBEEF);
    idle_cycle();
    do_req(1, 0, 2'b10, 0, 32'h8, 0);  check("lw_8", rsp_rdata, 32'hDEADBEEF);

    // Byte RMW.
    do_req(0, 1, 2'b00, 0, 32'h6, 32'h0000005A);
    check("sb_wdata", mem_wdata, 32'h115A3344);
    idle_cycle();
    check("sb_count", 32'(rmw_count), 32'h1);
    do_req(1, 0, 2'b10, 0, 32'h4, 0);  check("lw_4", rsp_rdata, 32'h115A3344);

    // Back-to-back halfword RMWs on the same word.
    do_req(0, 1, 2'b01, 0, 32'h0, 32'h0000CAFE);
    check("sh0_wdata", mem_wdata, 32'h8899CAFE);
    do_req(1, 1, 2'b01, 0, 32'h2, 32'hFFFF1234);
    check("sh2_wdata", mem_wdata, 32'h1234CAFE);
    do_req(1, 0, 2'b10, 0, 32'h0, 0);  check("lw_0", rsp_rdata, 32'h1234CAFE);

    // Reset during the write phase of a byte RMW.
    @(negedge clk);
    req_valid = 1'b1; req_read = 1'b0; req_write = 1'b1; req_size = 2'b00;
    req_signed = 1'b0; req_addr = 32'h4; req_wdata = 32'h77;
    #1;
    check("abort_rmw1_stall", 32'(stall), 32'h1);
    @(negedge clk);
    #1;
    check("abort_rmw2_write", 32'(mem_write), 32'h1);
    reset = 1'b1;
    #1;
    check_quiet("abort");
    check("abort_rmw_count", 32'(rmw_count), 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b0;
    exp_cnt = 0;
    do_req(1, 0, 2'b10, 0, 32'h4, 0);  check("abort_lw_4", rsp_rdata, 32'h115A3344);
    do_req(0, 1, 2'b00, 0, 32'h7, 32'h99);

    // Word load from a misaligned address.
    do_req(1, 0, 2'b10, 0, 32'h2, 0);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    check("lw_mis_exc", 32'(misalign_exc), 32'h1);
`else
    check("lw_mis_word0", rsp_rdata, 32'h1234CAFE);
`endif

    // Random traffic, including reserved size, read+write and no-command requests.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 7) == 0) idle_cycle();
      else do_req(1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom);
    end
    idle_cycle();
    check("final_rmw_count", 32'(rmw_count), 32'(exp_cnt));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
